// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe_if
// Description : Input/output handshake bundle for the registered immediate
//               generator (instruction in, decoded immediate out).
// Revision    : 1.0  initial release
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_ir;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_immed;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_ir, in_tag, out_ready,
        output in_ready, out_valid, out_immed, out_fmt, out_illegal, out_tag
    );

    modport master (
        output in_valid, in_ir, in_tag, out_ready,
        input  in_ready, out_valid, out_immed, out_fmt, out_illegal, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered RV32I/RV64I immediate generator with valid/ready
//               handshake, tag pass-through and flush. Define IMMGEN_SKID_EN
//               for the 2-entry skid variant with a registered in_ready.
// Revision    : 1.0  initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  wire logic          CLK,
    input  wire logic          RST_N,
    input  wire logic          flush,
    imm_gen_pipe_if.slave      bus
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_RG3 = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;
    localparam logic [2:0] FMT_SH   = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  immed;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0] ir;
    logic [31:0] imm32;
    logic [5:0]  shamt;
    logic [2:0]  dec_fmt;
    logic        dec_ill;
    entry_t      dec;

    assign ir    = bus.in_ir;
    assign shamt = (XLEN == 64) ? ir[25:20] : {1'b0, ir[24:20]};

    // Every format yields bit 31 equal to its sign, so one sign-extension to XLEN serves all.
    always_comb begin
        imm32   = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (ir[6:0])
            OPC_LOAD, OPC_JALR: begin
                imm32   = {{20{ir[31]}}, ir[31:20]};
                dec_fmt = FMT_I;
            end
            OPC_OP_IMM: begin
                if (ir[13:12] == 2'b01) begin
                    imm32   = {26'b0, shamt};
                    dec_fmt = FMT_SH;
                end else begin
                    imm32   = {{20{ir[31]}}, ir[31:20]};
                    dec_fmt = FMT_I;
                end
            end
            OPC_STORE: begin
                imm32   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                dec_fmt = FMT_S;
            end
            OPC_BRANCH: begin
                imm32   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                dec_fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32   = {ir[31:12], 12'b0};
                dec_fmt = FMT_U;
            end
            OPC_JAL: begin
                imm32   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
                dec_fmt = FMT_J;
            end
            OPC_SYS: begin
                if (ir[14]) begin
                    imm32   = {27'b0, ir[19:15]};
                    dec_fmt = FMT_Z;
                end
            end
            OPC_OP_RG3: begin
                dec_fmt = FMT_NONE;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    assign dec.immed   = XLEN'(signed'(imm32));
    assign dec.fmt     = dec_fmt;
    assign dec.illegal = dec_ill;
    assign dec.tag     = bus.in_tag;

    entry_t main_q, main_d;
    logic   main_valid_q, main_valid_d;
    logic   rdy;

`ifdef IMMGEN_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_empty_q, skid_empty_d;
    logic   accept;
    logic   pop;

    assign rdy    = skid_empty_q | flush;
    assign accept = bus.in_valid & skid_empty_q & ~flush;
    assign pop    = main_valid_q & bus.out_ready;

    // Skid contents always move to main before any new beat, keeping order.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_empty_d = skid_empty_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_empty_d = 1'b1;
        end else if (!main_valid_q || pop) begin
            if (!skid_empty_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_empty_d = 1'b1;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_empty_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_empty_q <= 1'b1;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_empty_q <= skid_empty_d;
        end
    end
`else
    logic load;

    assign rdy  = flush | ~main_valid_q | bus.out_ready;
    assign load = bus.in_valid & rdy & ~flush;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (load) begin
            main_d       = dec;
            main_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
        end
    end
`endif

    assign bus.in_ready    = rdy;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_immed   = main_q.immed;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_tag     = main_q.tag;

endmodule
`default_nettype wire
